// File: rtl/mem_byte_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_sequencer_if
// Purpose  : Bundles the fetch requester, the load/store requester and the
//            byte-wide memory array port of mem_byte_sequencer.
// Modports : master - requesters plus memory array (drives requests and
//                     mem_rdata; receives acks, rdata and the array strobes)
//            slave  - the sequencer itself
// Revision : 1.0 - initial release
// ============================================================================
interface mem_byte_sequencer_if;
  // fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;
  // load/store requester
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic        ls_err;
  logic [31:0] ls_rdata;
  // memory array port
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        IorD;

  modport master (
    output if_req, if_addr,
    input  if_ack, if_err, if_rdata,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_ack, ls_err, ls_rdata,
    input  mem_addr, mem_we, mem_wdata, IorD,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_err, if_rdata,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_ack, ls_err, ls_rdata,
    output mem_addr, mem_we, mem_wdata, IorD,
    input  mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_sequencer
// Purpose  : Shares a single byte-wide memory port between the fetch and the
//            load/store requesters of a multicycle RV32I core. One byte per
//            clock; 8/16/32-bit little-endian transfers are split/assembled.
//            Misaligned and out-of-range requests are rejected at grant.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - mem_byte_sequencer_if.slave (requests, acks, read data,
//                    memory address/strobe/data, IorD)
// Params   : MEM_BYTES - array size in bytes (valid addresses 0..MEM_BYTES-1)
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_sequencer #(
  parameter int MEM_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_byte_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // transfer context latched at grant
  logic        r_is_if;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_last_k;
  logic [1:0]  r_k;
  logic [31:0] r_asm;
  logic        r_prio_ls;     // 1: ls wins when both requests are high
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;

  // grant-time decode
  logic        w_any_req;
  logic        w_pick_ls;
  logic [31:0] w_g_addr;
  logic [1:0]  w_g_size;
  logic [2:0]  w_nbytes;
  logic        w_g_err;
  logic [31:0] w_asm_nxt;

  assign w_any_req = bus.if_req | bus.ls_req;
  // A lone request always wins; the pointer only breaks ties.
  assign w_pick_ls = bus.ls_req & (~bus.if_req | r_prio_ls);
  assign w_g_addr  = w_pick_ls ? bus.ls_addr : bus.if_addr;
  assign w_g_size  = w_pick_ls ? bus.ls_size : 2'b10;

  always_comb begin
    w_nbytes = 3'd1;
    case (w_g_size)
      2'b01:   w_nbytes = 3'd2;
      2'b10:   w_nbytes = 3'd4;
      default: w_nbytes = 3'd1;
    endcase
  end

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap.
  assign w_g_err = (w_g_size == 2'b11)
                 | ((w_g_size == 2'b01) & w_g_addr[0])
                 | ((w_g_size == 2'b10) & (w_g_addr[1:0] != 2'b00))
                 | (({1'b0, w_g_addr} + 33'(w_nbytes)) > 33'(MEM_BYTES));

  // Assembly register with the current byte merged into lane k.
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[{r_k, 3'b000} +: 8] = bus.mem_rdata;
  end

  assign bus.if_rdata = r_if_rdata;
  assign bus.ls_rdata = r_ls_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt   = r_state;
    bus.if_ack    = 1'b0;
    bus.if_err    = 1'b0;
    bus.ls_ack    = 1'b0;
    bus.ls_err    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'd0;
    bus.IorD      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = w_g_err ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        bus.mem_addr = r_addr + 32'(r_k);
        bus.IorD     = r_is_if;
        if (r_we) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = r_wdata[{r_k, 3'b000} +: 8];
        end
        if (r_k == r_last_k) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.if_ack  = r_is_if;
        bus.if_err  = r_is_if & r_err;
        bus.ls_ack  = ~r_is_if;
        bus.ls_err  = ~r_is_if & r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_if    <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_last_k   <= 2'd0;
      r_k        <= 2'd0;
      r_asm      <= 32'd0;
      r_prio_ls  <= 1'b1;
      r_if_rdata <= 32'd0;
      r_ls_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_is_if   <= ~w_pick_ls;
            r_we      <= w_pick_ls & bus.ls_we;
            r_err     <= w_g_err;
            r_addr    <= w_g_addr;
            r_wdata   <= bus.ls_wdata;
            r_last_k  <= 2'(w_nbytes - 3'd1);
            r_k       <= 2'd0;
            r_asm     <= 32'd0;
            r_prio_ls <= ~w_pick_ls;
          end
        end
        S_ACCESS: begin
          r_k <= r_k + 2'd1;
          if (!r_we) begin
            r_asm <= w_asm_nxt;
            // Publish on the last byte so rdata is valid alongside the ack.
            if (r_k == r_last_k) begin
              if (r_is_if) r_if_rdata <= w_asm_nxt;
              else         r_ls_rdata <= w_asm_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Sequences the byte-wide instruction/data memory array for the multicycle RV32I core, sharing its single port between the fetch requester and the load/store requester. It performs one byte access per clock and assembles or splits 8/16/32-bit little-endian transfers. It also drives the `IorD` select toward the memory and reports misaligned or out-of-range requests.

## Interface
- `MEM_BYTES`, 64: memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle pulse: fetch complete.
- `if_err`  out  1  valid with `if_ack`: misaligned or out of range.
- `if_rdata`  out  32  fetched word; held until the next fetch completes.
- `ls_req`  in  1  load/store request; held high until `ls_ack`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as an error.
- `ls_addr`  in  32  load/store byte address.
- `ls_wdata`  in  32  store data, right-aligned.
- `ls_ack`  out  1  one-cycle pulse: load/store complete.
- `ls_err`  out  1  valid with `ls_ack`.
- `ls_rdata`  out  32  load data, zero-extended and right-aligned; held until the next load completes.
- `mem_addr`  out  32  byte address to the array; 0 outside ACCESS.
- `mem_we`  out  1  byte write strobe.
- `mem_wdata`  out  8  byte write data.
- `mem_rdata`  in  8  combinational read byte at `mem_addr`.
- `IorD`  out  1  1 = instruction access in progress; 0 otherwise.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE, no request:** with neither request high, remain in IDLE.
- **Grant:** on a request, grant one requester and latch its address, size, write enable and write data.
  - Fetch is always treated as size 10.
  - The latched values are used for the whole transfer. Input changes after the grant are ignored.
  - The requester then goes to ACCESS, or to DONE with the error flag set if checks fail.
- **Arbitration:** round-robin between the two requesters.
  - After reset the priority pointer favours ls.
  - When both requests are high, the requester not granted last wins.
  - With a single request, that requester wins regardless of the pointer.
- **Error checks (at grant):**
  - size 11;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 00;
  - `addr + nbytes > MEM_BYTES`.
  - On error, no memory cycle occurs.
  - For an erroring load or fetch, the rdata outputs keep their previous value.
- **ACCESS:**
  - The byte counter k runs 0..nbytes-1, where nbytes is 1, 2 or 4.
  - `mem_addr` = base + k.
  - `IorD` = 1 for a fetch.
  - For a store, `mem_we` = 1 and `mem_wdata` = `wdata[8k+7:8k]`.
  - For a read, `mem_rdata` is captured at the end of the cycle into byte lane k of the assembly register. Upper lanes are cleared at grant.
  - After the last byte, go to DONE.
- **DONE:**
  - Pulse the granted ack, with err as determined at grant.
  - Update the rdata output for a successful read.
  - Return to IDLE.
- **Dropped request:** a transfer always runs to completion once granted. If the request drops mid-transfer, the ack still pulses.
- **Request held after ack:** a request still high in the IDLE cycle after DONE is a new request.

## Timing
- **Reset values:** all outputs 0. State is IDLE, k = 0, priority pointer favours ls.
- **Reset mid-transfer:** returns to IDLE immediately with no ack. A partially written store is not rolled back.
- **Successful transfer:** request seen in IDLE at cycle 0. ACCESS runs cycles 1..nbytes. Ack and rdata appear in cycle nbytes+1. Earliest next grant is cycle nbytes+2.
  - Word latency is therefore 5 cycles to ack, with 6-cycle throughput.
  - Byte latency is 2 cycles to ack.
- **Error transfer:** ack and err appear in cycle 1. Next grant is cycle 2 at the earliest.
- **Acks:** `if_ack` and `ls_ack` are never high in the same cycle.
- **Write strobes:** `mem_we` is never high outside ACCESS or during a fetch.

## Test plan
- **Word fetch:** memory bytes 0..3 = 13,05,10,00; fetch `if_addr`=0 → `IorD`=1 for 4 cycles, `mem_addr` 0,1,2,3. Expect `if_ack` in cycle 5 with `if_rdata`=0x00100513 and `if_err`=0.
- **Half store, then word load:** store half 0xBEEF at address 0x22 → `mem_we` on addresses 0x22 (EF) then 0x23 (BE). Then a word load at 0x20 returns 0xBEEFxxxx, with xxxx the prior contents of bytes 0x20-0x21.
- **Simultaneous requests:** `if_req`, `ls_req` (byte load) held continuously from reset → ls is granted first, then fetch, then ls. Acks alternate and never overlap.
- **Errors:**
  - word load at 0x02 → `ls_ack` and `ls_err` in cycle 1, no `mem_we`, `ls_rdata` unchanged;
  - word fetch at 0x3E → `if_err`;
  - `ls_size`=11 → `ls_err`.
- **Dropped request:** `ls_req` drops after cycle 2 of a word store → all 4 bytes are still written and `ls_ack` still pulses.
- **Reset mid-transfer:** `rst_n` low during the third ACCESS cycle of a fetch → all outputs 0 asynchronously, no `if_ack`. A new fetch after release completes normally.
